serial_adder: RTL
=================

Name: serial_adder

Overview:
- Parametrised bit-serial adder/subtractor built around a single full-adder cell and a registered carry.
- Adds or subtracts two WIDTH-bit operands LSB-first, one bit per clock, under a start/busy/done handshake.
- Successor to the single-bit combinational adder cells, for area-constrained datapaths where WIDTH-cycle latency is acceptable.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk edge, honoured only in IDLE or DONE.
- sub  input  1  mode, sampled with start: 0 = a+b+cin, 1 = a-b.
- a  input  WIDTH  operand A, sampled with start.
- b  input  WIDTH  operand B, sampled with start.
- cin  input  1  carry-in for add mode, sampled with start; ignored when sub=1.
- busy  output  1  high while the FSM is in RUN.
- done  output  1  one-cycle pulse; sum/cout valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  carry out of the MSB; in sub mode 1 = no borrow (a >= b unsigned).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; all internal registers cleared. Reset mid-RUN aborts the operation with no done pulse.
- FSM states:
  - IDLE: start=1 -> RUN.
  - RUN: after WIDTH bit-steps -> DONE.
  - DONE: lasts one cycle. start=1 -> RUN (back-to-back); otherwise -> IDLE.
- Load on accept (edge T0):
  - A shift register <= a.
  - B shift register <= b, or ~b when sub=1.
  - Carry register <= cin, or 1 when sub=1.
  - Bit counter <= 0; sum register cleared.
- Each RUN edge (T0+1 .. T0+WIDTH):
  - Bit = A[0] ^ B[0] ^ carry; carry <= majority(A[0], B[0], carry).
  - A and B shift right by 1; the bit shifts into sum from the MSB side.
  - Counter increments.
- Latency: at edge T0+WIDTH the state becomes DONE; done=1 and sum/cout are valid in the cycle after that edge. Latency is WIDTH cycles from the accepting edge. Throughput is one operation per WIDTH+1 cycles (start held high through DONE).
- busy=1 exactly during the WIDTH RUN cycles. start while busy is ignored; operands are not resampled.
- sum and cout do not change during RUN as seen at the ports. They are updated only at the transition into DONE (the internal shift register is separate) and held through IDLE.
- Arithmetic is modulo 2^WIDTH; cout captures the final carry. Counter width is clog2(WIDTH+1).
- Input changes on a, b, sub, cin outside the accepting edge have no effect.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit): signed two's-complement overflow = carry into MSB XOR carry out of MSB.
  - ovf is updated with sum/cout on entry to DONE, reset to 0, and held until the next result.
- When undefined: port ovf and its logic are absent; all other behaviour is identical.

Test Plan (WIDTH=8):
- a=0x00, b=0x00, cin=0, sub=0 -> done pulse 8 cycles after start edge; sum=0x00, cout=0; busy high exactly 8 cycles.
- a=0x5A, b=0xA5, cin=1, sub=0 -> sum=0x00, cout=1. Also a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1 (carry ripple through all bits).
- sub=1: a=0x10, b=0x01 -> sum=0x0F, cout=1; then a=0x00, b=0x01 -> sum=0xFF, cout=0. The second op is started during the DONE cycle of the first and its done pulse arrives 8 cycles later.
- start pulsed with a=0x33 during RUN of op a=0x01, b=0x02 -> ignored; result sum=0x03, cout=0; exactly one done pulse.
- rst_n dropped at RUN cycle 4 of a=0xF0, b=0x0F -> busy/done/sum/cout immediately 0, state IDLE; after release, a=0x01, b=0x01 -> sum=0x02.
- With SERIAL_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x80, ovf=1, cout=0; sub a=0x80, b=0x01 -> sum=0x7F, ovf=1, cout=1.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell, LSB-first, WIDTH cycles per operation.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output port ovf.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic             r_ovf;

  logic             w_bit;
  logic             w_carryNext;
  logic             w_accept;

  assign w_bit       = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_carryNext = (r_a[0] & r_b[0]) | (r_a[0] & r_carry) | (r_b[0] & r_carry);
  assign w_accept    = start && (r_state != RUN);

  // Result and flags live in their own registers so the ports stay frozen while r_shift fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_busy  <= 1'b1;
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_cnt   <= '0;
            r_shift <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_carryNext;
          r_shift <= {w_bit, r_shift[WIDTH-1:1]};
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST_STEP) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_sum   <= {w_bit, r_shift[WIDTH-1:1]};
            r_cout  <= w_carryNext;
            // On the MSB step r_carry is the carry into the MSB.
            r_ovf   <= r_carry ^ w_carryNext;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  assign ovf = r_ovf;
`else
  logic w_ovfUnused;
  assign w_ovfUnused = r_ovf;
`endif

endmodule
